btn_conditioner: RTL and testbench

//  Conditions the raw push-button inputs into the clean one-cycle step pulses that
//  the frequency divider's button[1:0] speed controls consume.
//  - Synchronises each button, debounces it on the 1 ms tick, and emits press pulses.
//  - Emits timed auto-repeat pulses while a button stays held.
//  - Sits between the board pins and f_div; its ms_tick comes from f_div's m_f.

---
 rtl/btn_conditioner.sv | 176 +++++++++++++++++
 tb/tb_btn_conditioner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: turns raw push-button pins into debounced levels and
// one-cycle step pulses (press + timed auto-repeat) for f_div's speed controls.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   ms_tick    one-cycle pulse every 1 ms (f_div m_f)
//   btn_raw    [N_BTN] asynchronous pin levels, 1 = pressed
//   btn_level  [N_BTN] debounced level per button
//   btn_pulse  [N_BTN] one-cycle pulse on accepted press and each repeat
//   btn_chord  1 while every debounced level is 1; gates all pulses off
//
// btn_channel (same file) is the per-button debounce/repeat FSM. It sees
// only the synchronised level; the top owns the synchronisers and chord gate.

module btn_channel #(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int CW              = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic sync_i,
  output logic level,
  output logic pulse
);

  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

  localparam logic [CW-1:0] DB_TGT   = CW'(DEBOUNCE_MS);
  localparam logic [CW-1:0] DLY_TGT  = CW'(REPEAT_DELAY_MS);
  localparam logic [CW-1:0] RATE_TGT = CW'(REPEAT_RATE_MS);
  localparam bit            REP_EN   = (REPEAT_RATE_MS != 0);

  state_t        state;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] rep_cnt;
  logic          rep_first;  // next repeat is the long initial delay
  logic [CW-1:0] db_inc;
  logic [CW-1:0] rep_inc;
  logic [CW-1:0] rep_tgt;

  // Saturating increments: counters park at all-ones instead of wrapping.
  assign db_inc  = (db_cnt  == '1) ? db_cnt  : db_cnt  + 1'b1;
  assign rep_inc = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;
  assign rep_tgt = rep_first ? DLY_TGT : RATE_TGT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      db_cnt    <= '0;
      rep_cnt   <= '0;
      rep_first <= 1'b1;
      level     <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      pulse <= 1'b0;
      // A level change always wins over a coincident tick: the tick is
      // dropped so a bounce never advances a counter.
      case (state)
        IDLE: begin
          if (sync_i) begin
            state  <= DB_PRESS;
            db_cnt <= '0;
          end
        end
        DB_PRESS: begin
          if (!sync_i) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (ms_tick) begin
            if (db_inc >= DB_TGT) begin
              state     <= HELD;
              level     <= 1'b1;
              pulse     <= 1'b1;
              db_cnt    <= '0;
              rep_cnt   <= '0;
              rep_first <= 1'b1;
            end else begin
              db_cnt <= db_inc;
            end
          end
        end
        HELD: begin
          if (!sync_i) begin
            state  <= DB_RELEASE;
            db_cnt <= '0;
          end else if (ms_tick) begin
            if (REP_EN && (rep_inc >= rep_tgt)) begin
              pulse     <= 1'b1;
              rep_cnt   <= '0;
              rep_first <= 1'b0;
            end else begin
              rep_cnt <= rep_inc;
            end
          end
        end
        DB_RELEASE: begin
          // Bounce back to HELD resumes the repeat schedule where it was.
          if (sync_i) begin
            state <= HELD;
          end else if (ms_tick) begin
            if (db_inc >= DB_TGT) begin
              state  <= IDLE;
              level  <= 1'b0;
              db_cnt <= '0;
            end else begin
              db_cnt <= db_inc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

module btn_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ms_tick,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             btn_chord
);

  localparam int MAX_DR = (DEBOUNCE_MS > REPEAT_DELAY_MS) ? DEBOUNCE_MS : REPEAT_DELAY_MS;
  localparam int MAXP   = (MAX_DR > REPEAT_RATE_MS) ? MAX_DR : REPEAT_RATE_MS;
  localparam int CW     = $clog2(MAXP + 1);

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] sync_q2;
  logic [N_BTN-1:0] pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1   <= '0;
      sync_q2   <= '0;
      btn_chord <= 1'b0;
    end else begin
      sync_q1   <= btn_raw;
      sync_q2   <= sync_q1;
      btn_chord <= &btn_level;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
      .REPEAT_RATE_MS (REPEAT_RATE_MS),
      .CW             (CW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .ms_tick(ms_tick),
      .sync_i (sync_q2[i]),
      .level  (btn_level[i]),
      .pulse  (pulse_q[i])
    );
  end

  // Both operands are flops, so the gated pulse stays glitch-free. Repeat
  // counters keep running underneath while the chord holds pulses off.
  assign btn_pulse = pulse_q & {N_BTN{~btn_chord}};

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: ms_tick every 4 clk, DEBOUNCE_MS=3,
// REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2 (dut) and REPEAT_RATE_MS=0 (dut_nr).
// Pulses are logged with their tick index relative to an aligned tick edge.
module tb_btn_conditioner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ms_tick = 1'b0;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_raw_b = 2'b00;
  logic [1:0] btn_level, btn_pulse, lvl_b, pls_b;
  logic       btn_chord, chord_b;

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  int base = 0;
  int phase = 0;
  int wide = 0;
  int pq0[$];
  int pq1[$];
  int pqb0[$];
  logic [1:0] prev_pulse = 2'b00;
  logic [1:0] prev_pb = 2'b00;
  logic [1:0] lvl_seen = 2'b00;

  btn_conditioner #(.N_BTN(2), .DEBOUNCE_MS(3), .REPEAT_DELAY_MS(5), .REPEAT_RATE_MS(2)) dut (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_chord(btn_chord));

  btn_conditioner #(.N_BTN(2), .DEBOUNCE_MS(3), .REPEAT_DELAY_MS(5), .REPEAT_RATE_MS(0)) dut_nr (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .btn_raw(btn_raw_b),
    .btn_level(lvl_b), .btn_pulse(pls_b), .btn_chord(chord_b));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    phase = (phase + 1) % 4;
    ms_tick = (phase == 0);
  end

  always @(posedge clk) if (ms_tick) tick_cnt <= tick_cnt + 1;

  task automatic step();
    @(posedge clk); #1;
    if (btn_pulse[0]) pq0.push_back(tick_cnt - base);
    if (btn_pulse[1]) pq1.push_back(tick_cnt - base);
    if (pls_b[0]) pqb0.push_back(tick_cnt - base);
    if (((btn_pulse & prev_pulse) != 2'b00) || ((pls_b & prev_pb) != 2'b00)) wide++;
    prev_pulse = btn_pulse;
    prev_pb = pls_b;
    lvl_seen = lvl_seen | btn_level;
  endtask

  task automatic run_to(input int rel);
    int guard;
    guard = 0;
    while ((tick_cnt - base < rel) && (guard < 400)) begin
      step();
      guard++;
    end
    if (guard >= 400) begin
      checks++; failures++;
      $display("FAIL run_to timeout: reached tick %0d required %0d", tick_cnt - base, rel);
    end
  endtask

  task automatic align();
    int t0;
    t0 = tick_cnt;
    while (tick_cnt == t0) step();
    base = tick_cnt;
    pq0.delete(); pq1.delete(); pqb0.delete();
    lvl_seen = 2'b00;
    wide = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_raw = 2'b11;
    btn_raw_b = 2'b11;
    repeat (16) step();
    checks++;
    if ({btn_level, btn_pulse, btn_chord} !== 5'b0)
      begin failures++; $display("FAIL reset_hold dut: got %b required 00000", {btn_level, btn_pulse, btn_chord}); end
    checks++;
    if ({lvl_b, pls_b, chord_b} !== 5'b0)
      begin failures++; $display("FAIL reset_hold dut_nr: got %b required 00000", {lvl_b, pls_b, chord_b}); end
    btn_raw = 2'b00;
    btn_raw_b = 2'b00;
    step();
    rst = 1'b0;
    repeat (8) step();
    checks++;
    if ({btn_level, btn_pulse, btn_chord} !== 5'b0)
      begin failures++; $display("FAIL reset_release: got %b required 00000", {btn_level, btn_pulse, btn_chord}); end
  endtask

  task automatic test_press();
    align();
    btn_raw[0] = 1'b1;
    run_to(2);
    checks++;
    if (btn_level[0] !== 1'b0)
      begin failures++; $display("FAIL press_early_level: got %b required 0", btn_level[0]); end
    run_to(3);
    checks++;
    if ({btn_pulse[0], btn_level[0]} !== 2'b11)
      begin failures++; $display("FAIL press_accept pulse/level: got %b required 11", {btn_pulse[0], btn_level[0]}); end
    step();
    checks++;
    if (btn_pulse[0] !== 1'b0)
      begin failures++; $display("FAIL press_width: got %b required 0", btn_pulse[0]); end
    run_to(4);
    checks++;
    if ((pq1.size() != 0) || (lvl_seen[1] !== 1'b0))
      begin failures++; $display("FAIL press_quiet_ch1: got pulses=%0d level_seen=%b required 0/0", pq1.size(), lvl_seen[1]); end
  endtask

  task automatic test_repeat();
    int e[5] = '{3, 8, 10, 12, 14};
    run_to(15);
    checks++;
    if (pq0.size() != 5) begin
      failures++; $display("FAIL repeat_count: got %0d required 5", pq0.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (pq0[i] != e[i])
          begin failures++; $display("FAIL repeat_tick[%0d]: got %0d required %0d", i, pq0[i], e[i]); end
      end
    end
    checks++;
    if (wide != 0) begin failures++; $display("FAIL repeat_width: got %0d wide pulses required 0", wide); end
    btn_raw[0] = 1'b0;
    run_to(21);
    checks++;
    if ((btn_level[0] !== 1'b0) || (pq0.size() != 5))
      begin failures++; $display("FAIL release_no_pulse: got level=%b pulses=%0d required 0/5", btn_level[0], pq0.size()); end
  endtask

  task automatic test_glitch();
    align();
    btn_raw[1] = 1'b1;
    run_to(2);
    btn_raw[1] = 1'b0;
    run_to(3);
    btn_raw[1] = 1'b1;
    run_to(5);
    btn_raw[1] = 1'b0;
    run_to(9);
    checks++;
    if (lvl_seen[1] !== 1'b0) begin failures++; $display("FAIL glitch_level: got 1 required 0"); end
    checks++;
    if (pq1.size() != 0) begin failures++; $display("FAIL glitch_pulse: got %0d pulses required 0", pq1.size()); end
  endtask

  task automatic test_chord();
    align();
    btn_raw[0] = 1'b1;
    run_to(2);
    btn_raw[1] = 1'b1;
    run_to(5);
    checks++;
    if ({btn_pulse[1], btn_chord} !== 2'b10)
      begin failures++; $display("FAIL chord_accept1: got pulse1/chord=%b required 10", {btn_pulse[1], btn_chord}); end
    step();
    checks++;
    if (btn_chord !== 1'b1) begin failures++; $display("FAIL chord_rise: got %b required 1", btn_chord); end
    run_to(11);
    checks++;
    if ((pq0.size() != 1) || (pq1.size() != 1))
      begin failures++; $display("FAIL chord_suppress: got p0=%0d p1=%0d required 1/1", pq0.size(), pq1.size()); end
    btn_raw[1] = 1'b0;
    run_to(14);
    checks++;
    if ({btn_level[1], btn_chord, btn_pulse[0]} !== 3'b010)
      begin failures++; $display("FAIL chord_release: got lvl1/chord/p0=%b required 010", {btn_level[1], btn_chord, btn_pulse[0]}); end
    step();
    checks++;
    if (btn_chord !== 1'b0) begin failures++; $display("FAIL chord_fall: got %b required 0", btn_chord); end
    run_to(19);
    checks++;
    if ((pq0.size() != 3) || (pq1.size() != 1))
      begin failures++; $display("FAIL chord_resume_count: got p0=%0d p1=%0d required 3/1", pq0.size(), pq1.size()); end
    else begin
      checks++;
      if ((pq0[1] != 16) || (pq0[2] != 18))
        begin failures++; $display("FAIL chord_resume_ticks: got %0d,%0d required 16,18", pq0[1], pq0[2]); end
    end
    btn_raw[0] = 1'b0;
    run_to(25);
    checks++;
    if (btn_level !== 2'b00) begin failures++; $display("FAIL chord_cleanup: got %b required 00", btn_level); end
  endtask

  task automatic test_reset_mid();
    align();
    btn_raw[0] = 1'b1;
    run_to(6);
    checks++;
    if (btn_level[0] !== 1'b1) begin failures++; $display("FAIL midrst_held: got %b required 1", btn_level[0]); end
    rst = 1'b1;
    step();
    checks++;
    if ({btn_level, btn_pulse, btn_chord} !== 5'b0)
      begin failures++; $display("FAIL midrst_clear: got %b required 00000", {btn_level, btn_pulse, btn_chord}); end
    rst = 1'b0;
    pq0.delete();
    run_to(12);
    checks++;
    if ((pq0.size() != 1) || (btn_level[0] !== 1'b1))
      begin failures++; $display("FAIL midrst_repress: got pulses=%0d level=%b required 1/1", pq0.size(), btn_level[0]); end
    else begin
      checks++;
      if (pq0[0] != 10) begin failures++; $display("FAIL midrst_tick: got %0d required 10", pq0[0]); end
    end
    btn_raw[0] = 1'b0;
    run_to(18);
  endtask

  task automatic test_norepeat();
    align();
    btn_raw_b[0] = 1'b1;
    run_to(23);
    checks++;
    if ((pqb0.size() != 1) || (lvl_b[0] !== 1'b1))
      begin failures++; $display("FAIL norep_count: got pulses=%0d level=%b required 1/1", pqb0.size(), lvl_b[0]); end
    else begin
      checks++;
      if (pqb0[0] != 3) begin failures++; $display("FAIL norep_tick: got %0d required 3", pqb0[0]); end
    end
    btn_raw_b[0] = 1'b0;
    run_to(25);
    checks++;
    if (lvl_b[0] !== 1'b1) begin failures++; $display("FAIL norep_release_early: got %b required 1", lvl_b[0]); end
    run_to(26);
    checks++;
    if (lvl_b[0] !== 1'b0) begin failures++; $display("FAIL norep_release: got %b required 0", lvl_b[0]); end
    checks++;
    if ((pqb0.size() != 1) || (wide != 0))
      begin failures++; $display("FAIL norep_release_pulse: got pulses=%0d wide=%0d required 1/0", pqb0.size(), wide); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_repeat();
    test_glitch();
    test_chord();
    test_reset_mid();
    test_norepeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
